// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the hardwired control sequencer: state codes, opcodes,
// IR field positions and the packed strobe bundle driven toward the datapath.
package ctrl_pkg;

    localparam int OPCODE_W = 5;
    localparam int FIELD_W  = 4;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    localparam logic [3:0] ST_RESET = 4'd0;
    localparam logic [3:0] ST_T0    = 4'd1;
    localparam logic [3:0] ST_T1    = 4'd2;
    localparam logic [3:0] ST_T2    = 4'd3;
    localparam logic [3:0] ST_T3    = 4'd4;
    localparam logic [3:0] ST_T4    = 4'd5;
    localparam logic [3:0] ST_T5    = 4'd6;
    localparam logic [3:0] ST_HALT  = 4'd7;

    typedef enum logic [3:0] {
        S_RESET = ST_RESET,
        S_T0    = ST_T0,
        S_T1    = ST_T1,
        S_T2    = ST_T2,
        S_T3    = ST_T3,
        S_T4    = ST_T4,
        S_T5    = ST_T5,
        S_HALT  = ST_HALT
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

    typedef struct packed {
        logic run;
        logic pc_out;
        logic zlow_out;
        logic mdr_out;
        logic mar_in;
        logic z_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic inc_pc;
        logic read;
        logic alu_add;
        logic alu_sub;
        logic alu_and;
        logic alu_or;
    } strobe_t;

    function automatic logic is_alu_op(input logic [OPCODE_W-1:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: IR and handshake inputs, per-cycle strobes out.
// master = control unit side, slave = datapath side.
interface control_sequencer_if #(
    parameter int NUM_REGS = 16
);
    logic [31:0]         IR;
    logic                Mem_ready;
    logic                Stop;
    logic                Run;
    logic                PCout;
    logic                Zlowout;
    logic                MDRout;
    logic                MARin;
    logic                Zin;
    logic                PCin;
    logic                MDRin;
    logic                IRin;
    logic                Yin;
    logic                IncPC;
    logic                Read;
    logic                ADD;
    logic                SUB;
    logic                AND;
    logic                OR;
    logic [NUM_REGS-1:0] R_out;
    logic [NUM_REGS-1:0] R_in;
    logic [3:0]          state_dbg;

    modport master (
        input  IR, Mem_ready, Stop,
        output Run, PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
               IncPC, Read, ADD, SUB, AND, OR, R_out, R_in, state_dbg
    );

    modport slave (
        output IR, Mem_ready, Stop,
        input  Run, PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
               IncPC, Read, ADD, SUB, AND, OR, R_out, R_in, state_dbg
    );
endinterface

// File: rtl/control_sequencer_reg_select_decode.sv
// Register field to one-hot enable; purely combinational, zero latency.
// Field values beyond the register file decode to all-zero.
module reg_select_decode #(
    parameter int NUM_REGS = 16,
    parameter int FIELD_W  = 4
) (
    input  logic [FIELD_W-1:0]  field_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o
);
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot_o[i] = en_i && (32'(field_i) == 32'(i));
        end
    end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch (T0-T2) / reg-reg ALU execute (T3-T5) sequencer.
// Strobes are a same-cycle decode of the registered state; Mem_ready stalls T1.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    control_sequencer_if.master  bus
);

    state_t                state_q;
    state_t                state_d;
    strobe_t               stb;
    logic [OPCODE_W-1:0]   opcode;
    logic [FIELD_W-1:0]    ra;
    logic [FIELD_W-1:0]    rb;
    logic [FIELD_W-1:0]    rc;
    logic [FIELD_W-1:0]    rout_field;
    logic                  rout_en;
    logic                  rin_en;
    logic [NUM_REGS-1:0]   rout_vec;
    logic [NUM_REGS-1:0]   rin_vec;
    logic                  ir_unused;

    assign opcode    = bus.IR[OPC_MSB:OPC_LSB];
    assign ra        = bus.IR[RA_MSB:RA_LSB];
    assign rb        = bus.IR[RB_MSB:RB_LSB];
    assign rc        = bus.IR[RC_MSB:RC_LSB];
    assign ir_unused = ^bus.IR[RC_LSB-1:0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stb        = '0;
        rout_en    = 1'b0;
        rout_field = rb;
        rin_en     = 1'b0;

        case (state_q)
            S_RESET: begin
                state_d = S_T0;
            end
            S_T0: begin
                stb.run    = 1'b1;
                stb.pc_out = 1'b1;
                stb.mar_in = 1'b1;
                stb.inc_pc = 1'b1;
                stb.z_in   = 1'b1;
                state_d    = S_T1;
            end
            S_T1: begin
                // Strobes stay asserted for the whole memory wait.
                stb.run      = 1'b1;
                stb.zlow_out = 1'b1;
                stb.pc_in    = 1'b1;
                stb.read     = 1'b1;
                stb.mdr_in   = 1'b1;
                if (bus.Mem_ready) begin
                    state_d = S_T2;
                end
            end
            S_T2: begin
                stb.run     = 1'b1;
                stb.mdr_out = 1'b1;
                stb.ir_in   = 1'b1;
                state_d     = S_T3;
            end
            S_T3: begin
                stb.run = 1'b1;
                if (is_alu_op(opcode)) begin
                    rout_en  = 1'b1;
                    stb.y_in = 1'b1;
                    state_d  = S_T4;
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = bus.Stop ? S_HALT : S_T0;
                end
            end
            S_T4: begin
                stb.run    = 1'b1;
                stb.z_in   = 1'b1;
                rout_en    = 1'b1;
                rout_field = rc;
                case (opcode)
                    OP_ADD:  stb.alu_add = 1'b1;
                    OP_SUB:  stb.alu_sub = 1'b1;
                    OP_AND:  stb.alu_and = 1'b1;
                    OP_OR:   stb.alu_or  = 1'b1;
                    default: stb.alu_add = 1'b0;
                endcase
                state_d = S_T5;
            end
            S_T5: begin
                stb.run      = 1'b1;
                stb.zlow_out = 1'b1;
                rin_en       = 1'b1;
                state_d      = bus.Stop ? S_HALT : S_T0;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    reg_select_decode #(
        .NUM_REGS (NUM_REGS),
        .FIELD_W  (FIELD_W)
    ) u_rout_dec (
        .field_i  (rout_field),
        .en_i     (rout_en),
        .onehot_o (rout_vec)
    );

    reg_select_decode #(
        .NUM_REGS (NUM_REGS),
        .FIELD_W  (FIELD_W)
    ) u_rin_dec (
        .field_i  (ra),
        .en_i     (rin_en),
        .onehot_o (rin_vec)
    );

    assign bus.Run       = stb.run;
    assign bus.PCout     = stb.pc_out;
    assign bus.Zlowout   = stb.zlow_out;
    assign bus.MDRout    = stb.mdr_out;
    assign bus.MARin     = stb.mar_in;
    assign bus.Zin       = stb.z_in;
    assign bus.PCin      = stb.pc_in;
    assign bus.MDRin     = stb.mdr_in;
    assign bus.IRin      = stb.ir_in;
    assign bus.Yin       = stb.y_in;
    assign bus.IncPC     = stb.inc_pc;
    assign bus.Read      = stb.read;
    assign bus.ADD       = stb.alu_add;
    assign bus.SUB       = stb.alu_sub;
    assign bus.AND       = stb.alu_and;
    assign bus.OR        = stb.alu_or;
    assign bus.R_out     = rout_vec;
    assign bus.R_in      = rin_vec;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected per-cycle state/strobes are
// queued with each stimulus step and checked against the DUT one cycle at a time.
module tb_control_sequencer;

    localparam logic [15:0] C_RUN   = 16'h8000;
    localparam logic [15:0] C_PCOUT = 16'h4000;
    localparam logic [15:0] C_ZLOW  = 16'h2000;
    localparam logic [15:0] C_MDRO  = 16'h1000;
    localparam logic [15:0] C_MARIN = 16'h0800;
    localparam logic [15:0] C_ZIN   = 16'h0400;
    localparam logic [15:0] C_PCIN  = 16'h0200;
    localparam logic [15:0] C_MDRIN = 16'h0100;
    localparam logic [15:0] C_IRIN  = 16'h0080;
    localparam logic [15:0] C_YIN   = 16'h0040;
    localparam logic [15:0] C_INCPC = 16'h0020;
    localparam logic [15:0] C_READ  = 16'h0010;
    localparam logic [15:0] C_ADD   = 16'h0008;
    localparam logic [15:0] C_SUB   = 16'h0004;
    localparam logic [15:0] C_AND   = 16'h0002;
    localparam logic [15:0] C_OR    = 16'h0001;

    localparam logic [15:0] E_T0 = C_RUN | C_PCOUT | C_MARIN | C_INCPC | C_ZIN;
    localparam logic [15:0] E_T1 = C_RUN | C_ZLOW | C_PCIN | C_READ | C_MDRIN;
    localparam logic [15:0] E_T2 = C_RUN | C_MDRO | C_IRIN;

    localparam logic [31:0] IR_AND  = 32'h2891_8000;
    localparam logic [31:0] IR_ADD  = 32'h1891_8000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_UNDF = 32'hF800_0000;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic [15:0] rout;
        logic [15:0] rin;
    } exp_t;

    logic        Clock;
    logic        Reset;
    logic [15:0] ctl_obs;
    exp_t        sb[$];
    int          checks;
    int          failures;

    control_sequencer_if #(.NUM_REGS(16)) bus ();

    control_sequencer #(.NUM_REGS(16)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    assign ctl_obs = {bus.Run, bus.PCout, bus.Zlowout, bus.MDRout, bus.MARin, bus.Zin,
                      bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.IncPC, bus.Read,
                      bus.ADD, bus.SUB, bus.AND, bus.OR};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic push(input string tag, input logic [3:0] st, input logic [15:0] ctl,
                        input logic [15:0] ro, input logic [15:0] ri);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.ctl  = ctl;
        e.rout = ro;
        e.rin  = ri;
        sb.push_back(e);
    endtask

    // Compare the present cycle against the oldest expectation, then advance.
    task automatic cyc();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty got no expectation want one queued");
        end else begin
            e = sb.pop_front();
            checks++;
            assert (bus.state_dbg === e.st) else begin
                failures++;
                $error("FAIL %s.state got %0d want %0d", e.tag, bus.state_dbg, e.st);
            end
            checks++;
            assert (ctl_obs === e.ctl) else begin
                failures++;
                $error("FAIL %s.strobes got %h want %h", e.tag, ctl_obs, e.ctl);
            end
            checks++;
            assert (bus.R_out === e.rout) else begin
                failures++;
                $error("FAIL %s.R_out got %h want %h", e.tag, bus.R_out, e.rout);
            end
            checks++;
            assert (bus.R_in === e.rin) else begin
                failures++;
                $error("FAIL %s.R_in got %h want %h", e.tag, bus.R_in, e.rin);
            end
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [15:0] ctl,
                        input logic [15:0] ro, input logic [15:0] ri);
        push(tag, st, ctl, ro, ri);
        cyc();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        Reset         = 1'b1;
        bus.IR        = IR_AND;
        bus.Mem_ready = 1'b1;
        bus.Stop      = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        step("rst", 4'd0, 16'h0, 16'h0, 16'h0);

        // and r1,r2,r3 with memory always ready
        step("and_T0", 4'd1, E_T0, 16'h0, 16'h0);
        step("and_T1", 4'd2, E_T1, 16'h0, 16'h0);
        step("and_T2", 4'd3, E_T2, 16'h0, 16'h0);
        step("and_T3", 4'd4, C_RUN | C_YIN, 16'h0004, 16'h0);
        step("and_T4", 4'd5, C_RUN | C_ZIN | C_AND, 16'h0008, 16'h0);
        step("and_T5", 4'd6, C_RUN | C_ZLOW, 16'h0, 16'h0002);

        // memory stall: T1 held four cycles
        step("stl_T0", 4'd1, E_T0, 16'h0, 16'h0);
        bus.Mem_ready = 1'b0;
        step("stl_T1a", 4'd2, E_T1, 16'h0, 16'h0);
        step("stl_T1b", 4'd2, E_T1, 16'h0, 16'h0);
        step("stl_T1c", 4'd2, E_T1, 16'h0, 16'h0);
        bus.Mem_ready = 1'b1;
        step("stl_T1d", 4'd2, E_T1, 16'h0, 16'h0);
        step("stl_T2", 4'd3, E_T2, 16'h0, 16'h0);
        step("stl_T3", 4'd4, C_RUN | C_YIN, 16'h0004, 16'h0);
        step("stl_T4", 4'd5, C_RUN | C_ZIN | C_AND, 16'h0008, 16'h0);
        step("stl_T5", 4'd6, C_RUN | C_ZLOW, 16'h0, 16'h0002);

        // halt opcode parks the sequencer until reset
        bus.IR = IR_HALT;
        step("hlt_T0", 4'd1, E_T0, 16'h0, 16'h0);
        step("hlt_T1", 4'd2, E_T1, 16'h0, 16'h0);
        step("hlt_T2", 4'd3, E_T2, 16'h0, 16'h0);
        step("hlt_T3", 4'd4, C_RUN, 16'h0, 16'h0);
        for (int i = 0; i < 10; i++) begin
            step("hlt_park", 4'd7, 16'h0, 16'h0, 16'h0);
        end
        Reset = 1'b1;
        step("hlt_rstin", 4'd7, 16'h0, 16'h0, 16'h0);
        Reset = 1'b0;
        step("hlt_rst", 4'd0, 16'h0, 16'h0, 16'h0);

        // add with Stop raised in T4: instruction completes, then HALT
        bus.IR = IR_ADD;
        step("add_T0", 4'd1, E_T0, 16'h0, 16'h0);
        step("add_T1", 4'd2, E_T1, 16'h0, 16'h0);
        step("add_T2", 4'd3, E_T2, 16'h0, 16'h0);
        step("add_T3", 4'd4, C_RUN | C_YIN, 16'h0004, 16'h0);
        bus.Stop = 1'b1;
        step("add_T4", 4'd5, C_RUN | C_ZIN | C_ADD, 16'h0008, 16'h0);
        step("add_T5", 4'd6, C_RUN | C_ZLOW, 16'h0, 16'h0002);
        bus.Stop = 1'b0;
        step("add_halt", 4'd7, 16'h0, 16'h0, 16'h0);
        Reset = 1'b1;
        step("add_rstin", 4'd7, 16'h0, 16'h0, 16'h0);
        Reset = 1'b0;
        step("add_rst", 4'd0, 16'h0, 16'h0, 16'h0);

        // reset asserted during T4 aborts the and
        bus.IR = IR_AND;
        step("mid_T0", 4'd1, E_T0, 16'h0, 16'h0);
        step("mid_T1", 4'd2, E_T1, 16'h0, 16'h0);
        step("mid_T2", 4'd3, E_T2, 16'h0, 16'h0);
        step("mid_T3", 4'd4, C_RUN | C_YIN, 16'h0004, 16'h0);
        Reset = 1'b1;
        step("mid_T4", 4'd5, C_RUN | C_ZIN | C_AND, 16'h0008, 16'h0);
        Reset = 1'b0;
        step("mid_rst", 4'd0, 16'h0, 16'h0, 16'h0);
        step("mid_T0b", 4'd1, E_T0, 16'h0, 16'h0);

        // undefined opcode behaves as nop and refetches
        bus.IR = IR_UNDF;
        step("udf_T1", 4'd2, E_T1, 16'h0, 16'h0);
        step("udf_T2", 4'd3, E_T2, 16'h0, 16'h0);
        step("udf_T3", 4'd4, C_RUN, 16'h0, 16'h0);
        step("udf_T0", 4'd1, E_T0, 16'h0, 16'h0);

        // nop with Stop at its boundary halts
        step("nst_T1", 4'd2, E_T1, 16'h0, 16'h0);
        step("nst_T2", 4'd3, E_T2, 16'h0, 16'h0);
        bus.Stop = 1'b1;
        step("nst_T3", 4'd4, C_RUN, 16'h0, 16'h0);
        bus.Stop = 1'b0;
        step("nst_halt", 4'd7, 16'h0, 16'h0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
